// File: rtl/tt_cpu_pkg.sv
// ---------------------------------------------------------------------------
// tt_cpu_pkg
// Shared definitions for the TinyTapeout CPU host-loader path.
//   - loader_state_e : loader FSM states (IDLE / LOAD / RUN)
//   - INSTR_W, BYTES_PER_WORD : instruction word geometry
//   - IMEM_ADDR_W, IMEM_SYNC_STAGES : default instruction-memory address
//     width and input synchroniser depth
//   - insert_byte() : places one byte into a lane of a little-endian word
// ---------------------------------------------------------------------------
package tt_cpu_pkg;

  localparam int INSTR_W          = 32;
  localparam int BYTES_PER_WORD   = 4;
  localparam int IMEM_ADDR_W      = 6;
  localparam int IMEM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LOADER_IDLE = 2'd0,
    LOADER_LOAD = 2'd1,
    LOADER_RUN  = 2'd2
  } loader_state_e;

  // Little-endian lane insert: lane 0 holds the first byte received.
  function automatic logic [INSTR_W-1:0] insert_byte(
    input logic [INSTR_W-1:0] word,
    input logic [1:0]         idx,
    input logic [7:0]         data
  );
    logic [INSTR_W-1:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a STAGES-deep
// flop chain and produces registered one-cycle rise/fall pulses.
// A pin change shows up on rise_o/fall_o STAGES+1 cycles later.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   async_i     : asynchronous input level
//   level_o     : synchronised level
//   rise_o      : one-cycle pulse on a 0->1 transition of level_o
//   fall_o      : one-cycle pulse on a 1->0 transition of level_o
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchroniser chain and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/imem_byte_loader.sv
// ---------------------------------------------------------------------------
// imem_byte_loader
// Host-to-CPU program loader. Accepts bytes over an asynchronous strobe/ack
// handshake, packs them little-endian into 32-bit words and writes them into
// the instruction memory. Holds the CPU in reset while loading.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : program byte, stable while byte_stb is pending
//   byte_stb    : asynchronous strobe, rising edge offers a byte
//   load_en     : asynchronous level, 1 = load mode, 0 = run mode
//   byte_ack    : toggles once per accepted byte
//   imem_we     : one-cycle write pulse
//   imem_addr   : write word address (holds between writes)
//   imem_wdata  : write data (holds between writes)
//   cpu_rst_n   : active-low CPU reset
//   busy        : high while in LOAD
//   overflow    : sticky, a word completed after memory was full
//   word_cnt    : words written in the current/last load
// ---------------------------------------------------------------------------
module imem_byte_loader
  import tt_cpu_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int SYNC_STAGES = IMEM_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                byte_stb,
  input  logic                load_en,
  output logic                byte_ack,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                overflow,
  output logic [ADDR_W:0]     word_cnt
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
  localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

  // Synchronised handshake inputs.
  logic stb_level_s, stb_rise_s, stb_fall_s;
  logic load_level_s, load_rise_s, load_fall_s;
  logic unused_stb_s;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (byte_stb),
    .level_o (stb_level_s),
    .rise_o  (stb_rise_s),
    .fall_o  (stb_fall_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (load_en),
    .level_o (load_level_s),
    .rise_o  (load_rise_s),
    .fall_o  (load_fall_s)
  );

  // Only the rising edge of the strobe matters.
  assign unused_stb_s = stb_level_s ^ stb_fall_s;

  loader_state_e        state_q;
  logic [WARM_W-1:0]    warm_q;
  logic [1:0]           idx_q;
  logic [INSTR_W-1:0]   shift_q;
  logic [INSTR_W-1:0]   shift_d;
  logic                 wr_pend_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W:0]      cnt_q;
  logic                 ack_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic [INSTR_W-1:0]   wdata_q;
  logic                 cpu_rst_n_q;
  logic                 busy_q;
  logic                 ovf_q;
  logic                 capture_s;

  // Byte acceptance: LOAD only, and a simultaneous exit takes priority.
  always_comb begin
    capture_s = 1'b0;
    shift_d   = insert_byte(shift_q, idx_q, data_in);
    if ((state_q == LOADER_LOAD) && stb_rise_s && !load_fall_s) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Loader FSM with registered outputs and the one-cycle-late word write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOADER_IDLE;
      warm_q      <= '0;
      idx_q       <= 2'd0;
      shift_q     <= '0;
      wr_pend_q   <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;

      // A completed word is written the cycle after its last byte,
      // unless memory is already full.
      if (wr_pend_q) begin
        wr_pend_q <= 1'b0;
        if (cnt_q == FULL_CNT) begin
          ovf_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= shift_q;
          addr_q  <= addr_q + ADDR_W'(1);
          cnt_q   <= cnt_q + (ADDR_W+1)'(1);
        end
      end

      case (state_q)
        LOADER_IDLE: begin
          cpu_rst_n_q <= 1'b0;
          busy_q      <= 1'b0;
          // Wait for the load_en synchroniser to fill before deciding,
          // otherwise a held-high load_en would briefly release the CPU.
          if (warm_q == WARM_DONE) begin
            if (load_level_s) begin
              state_q   <= LOADER_LOAD;
              busy_q    <= 1'b1;
              idx_q     <= 2'd0;
              addr_q    <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              wr_pend_q <= 1'b0;
            end else begin
              state_q <= LOADER_RUN;
            end
          end else begin
            warm_q <= warm_q + WARM_W'(1);
          end
        end

        LOADER_LOAD: begin
          cpu_rst_n_q <= 1'b0;
          if (load_fall_s) begin
            // Partial bytes are dropped; idx is cleared on the next entry.
            state_q <= LOADER_RUN;
            busy_q  <= 1'b0;
          end else if (capture_s) begin
            shift_q <= shift_d;
            idx_q   <= idx_q + 2'd1;
            ack_q   <= ~ack_q;
            if (idx_q == 2'd3) begin
              wr_pend_q <= 1'b1;
            end
          end
        end

        LOADER_RUN: begin
          cpu_rst_n_q <= 1'b1;
          busy_q      <= 1'b0;
          if (load_rise_s) begin
            state_q   <= LOADER_LOAD;
            busy_q    <= 1'b1;
            idx_q     <= 2'd0;
            addr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_pend_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= LOADER_IDLE;
          cpu_rst_n_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ack   = ack_q;
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_byte_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_byte_loader
// Directed bench for imem_byte_loader. Two instances share all inputs: a
// default-size one (ADDR_W=6) and a small one (ADDR_W=2) used to reach the
// memory-full condition.
// ---------------------------------------------------------------------------
module tb_imem_byte_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        byte_stb;
  logic        load_en;

  logic        b_ack, b_we, b_crst, b_busy, b_ovf;
  logic [5:0]  b_addr;
  logic [31:0] b_wdata;
  logic [6:0]  b_cnt;

  logic        s_ack, s_we, s_crst, s_busy, s_ovf;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_cnt;

  int n_chk;
  int n_pass;

  logic [5:0]  b_addr_log[$];
  logic [31:0] b_data_log[$];
  logic [1:0]  s_addr_log[$];
  logic [31:0] s_data_log[$];
  int          b_acks;
  int          s_acks;
  logic        b_ack_prev;
  logic        s_ack_prev;

  imem_byte_loader #(.ADDR_W(6), .SYNC_STAGES(2)) u_big (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .byte_stb(byte_stb),
    .load_en(load_en), .byte_ack(b_ack), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_rst_n(b_crst), .busy(b_busy),
    .overflow(b_ovf), .word_cnt(b_cnt)
  );

  imem_byte_loader #(.ADDR_W(2), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .byte_stb(byte_stb),
    .load_en(load_en), .byte_ack(s_ack), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .cpu_rst_n(s_crst), .busy(s_busy),
    .overflow(s_ovf), .word_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and ack monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (b_we) begin
      b_addr_log.push_back(b_addr);
      b_data_log.push_back(b_wdata);
    end
    if (s_we) begin
      s_addr_log.push_back(s_addr);
      s_data_log.push_back(s_wdata);
    end
    if (b_ack !== b_ack_prev) b_acks = b_acks + 1;
    if (s_ack !== s_ack_prev) s_acks = s_acks + 1;
    b_ack_prev = b_ack;
    s_ack_prev = s_ack;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    b_addr_log.delete();
    b_data_log.delete();
    s_addr_log.delete();
    s_data_log.delete();
    b_acks = 0;
    s_acks = 0;
  endtask

  task automatic set_load(input logic v);
    load_en = v;
    wait_cycles(8);
  endtask

  // Offer one byte and wait (bounded) for the ack toggle.
  task automatic send_byte(input logic [7:0] b);
    logic start;
    bit   got;
    data_in  = b;
    start    = b_ack;
    got      = 1'b0;
    byte_stb = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_ack !== start) got = 1'b1;
    end
    n_chk++;
    if (!got) $display("FAIL ack_timeout byte=%h: no ack toggle, required a toggle", b);
    else n_pass++;
    byte_stb = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; byte_stb = 1'b0; data_in = 8'h00;
    wait_cycles(2);
    n_chk++; if ({b_ack, b_we, b_crst, b_busy, b_ovf} !== 5'b0) $display("FAIL reset_flags got %b required 00000", {b_ack, b_we, b_crst, b_busy, b_ovf}); else n_pass++;
    n_chk++; if (b_addr !== 6'd0 || b_wdata !== 32'd0 || b_cnt !== 7'd0) $display("FAIL reset_bus got addr=%h wdata=%h cnt=%h required 0", b_addr, b_wdata, b_cnt); else n_pass++;
    clear_logs();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (b_crst !== 1'b0) $display("FAIL run_latency_early got cpu_rst_n=%b required 0", b_crst); else n_pass++;
    @(posedge clk);
    #1;
    n_chk++; if (b_crst !== 1'b1 || b_busy !== 1'b0) $display("FAIL run_entry got cpu_rst_n=%b busy=%b required 1/0", b_crst, b_busy); else n_pass++;
  endtask

  task automatic test_run_ignores_strobe();
    clear_logs();
    data_in = 8'h5A;
    byte_stb = 1'b1;
    wait_cycles(8);
    byte_stb = 1'b0;
    wait_cycles(6);
    n_chk++; if (b_acks != 0 || b_ack !== 1'b0) $display("FAIL run_strobe_ack got acks=%0d ack=%b required 0/0", b_acks, b_ack); else n_pass++;
    n_chk++; if (b_addr_log.size() != 0) $display("FAIL run_strobe_write got %0d writes required 0", b_addr_log.size()); else n_pass++;
  endtask

  task automatic test_single_word();
    set_load(1'b1);
    n_chk++; if (b_busy !== 1'b1 || b_crst !== 1'b0) $display("FAIL load_entry got busy=%b cpu_rst_n=%b required 1/0", b_busy, b_crst); else n_pass++;
    clear_logs();
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    wait_cycles(3);
    n_chk++; if (b_addr_log.size() != 1) $display("FAIL single_write_count got %0d required 1", b_addr_log.size()); else n_pass++;
    if (b_addr_log.size() == 1) begin
      n_chk++; if (b_addr_log[0] !== 6'd0 || b_data_log[0] !== 32'h00A00513) $display("FAIL single_write got addr=%h data=%h required 00/00a00513", b_addr_log[0], b_data_log[0]); else n_pass++;
    end
    n_chk++; if (b_acks != 4) $display("FAIL single_acks got %0d required 4", b_acks); else n_pass++;
    n_chk++; if (b_cnt !== 7'd1) $display("FAIL single_cnt got %0d required 1", b_cnt); else n_pass++;
  endtask

  task automatic test_two_words();
    set_load(1'b0);
    set_load(1'b1);
    clear_logs();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_cycles(3);
    n_chk++; if (b_addr_log.size() != 2) $display("FAIL two_write_count got %0d required 2", b_addr_log.size()); else n_pass++;
    if (b_addr_log.size() == 2) begin
      n_chk++; if (b_addr_log[0] !== 6'd0 || b_data_log[0] !== 32'h04030201) $display("FAIL two_w0 got addr=%h data=%h required 00/04030201", b_addr_log[0], b_data_log[0]); else n_pass++;
      n_chk++; if (b_addr_log[1] !== 6'd1 || b_data_log[1] !== 32'h08070605) $display("FAIL two_w1 got addr=%h data=%h required 01/08070605", b_addr_log[1], b_data_log[1]); else n_pass++;
    end
    n_chk++; if (b_cnt !== 7'd2) $display("FAIL two_cnt got %0d required 2", b_cnt); else n_pass++;
    set_load(1'b0);
    n_chk++; if (b_crst !== 1'b1 || b_busy !== 1'b0 || b_cnt !== 7'd2) $display("FAIL two_exit got cpu_rst_n=%b busy=%b cnt=%0d required 1/0/2", b_crst, b_busy, b_cnt); else n_pass++;
  endtask

  task automatic test_overflow();
    set_load(1'b1);
    clear_logs();
    for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i));
    wait_cycles(3);
    n_chk++; if (s_addr_log.size() != 4) $display("FAIL ovf_write_count got %0d required 4", s_addr_log.size()); else n_pass++;
    for (int i = 0; i < s_addr_log.size() && i < 4; i++) begin
      n_chk++; if (s_addr_log[i] !== 2'(i)) $display("FAIL ovf_addr%0d got %0d required %0d", i, s_addr_log[i], i); else n_pass++;
    end
    if (s_data_log.size() == 4) begin
      n_chk++; if (s_data_log[0] !== 32'h13121110 || s_data_log[3] !== 32'h1F1E1D1C) $display("FAIL ovf_data got %h/%h required 13121110/1f1e1d1c", s_data_log[0], s_data_log[3]); else n_pass++;
    end
    n_chk++; if (s_ovf !== 1'b1 || s_cnt !== 3'd4) $display("FAIL ovf_flag got ovf=%b cnt=%0d required 1/4", s_ovf, s_cnt); else n_pass++;
    n_chk++; if (s_acks != 20) $display("FAIL ovf_acks got %0d required 20", s_acks); else n_pass++;
    n_chk++; if (s_addr !== 2'd3) $display("FAIL ovf_addr_hold got %0d required 3", s_addr); else n_pass++;
    n_chk++; if (b_addr_log.size() != 5 || b_ovf !== 1'b0) $display("FAIL big_no_ovf got writes=%0d ovf=%b required 5/0", b_addr_log.size(), b_ovf); else n_pass++;
  endtask

  task automatic test_partial_word();
    set_load(1'b0);
    set_load(1'b1);
    n_chk++; if (s_ovf !== 1'b0) $display("FAIL ovf_clear got %b required 0", s_ovf); else n_pass++;
    clear_logs();
    send_byte(8'h55); send_byte(8'h66);
    set_load(1'b0);
    n_chk++; if (b_addr_log.size() != 0) $display("FAIL partial_write got %0d writes required 0", b_addr_log.size()); else n_pass++;
    set_load(1'b1);
    clear_logs();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_cycles(3);
    n_chk++; if (b_addr_log.size() != 1) $display("FAIL partial_next_count got %0d required 1", b_addr_log.size()); else n_pass++;
    if (b_addr_log.size() == 1) begin
      n_chk++; if (b_addr_log[0] !== 6'd0 || b_data_log[0] !== 32'hDDCCBBAA) $display("FAIL partial_next got addr=%h data=%h required 00/ddccbbaa", b_addr_log[0], b_data_log[0]); else n_pass++;
    end
    n_chk++; if (s_ovf !== 1'b0) $display("FAIL partial_ovf got %b required 0", s_ovf); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h77); send_byte(8'h88);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({b_ack, b_we, b_crst, b_busy, b_ovf} !== 5'b0) $display("FAIL midrst_flags got %b required 00000", {b_ack, b_we, b_crst, b_busy, b_ovf}); else n_pass++;
    n_chk++; if (b_addr !== 6'd0 || b_wdata !== 32'd0 || b_cnt !== 7'd0) $display("FAIL midrst_bus got addr=%h wdata=%h cnt=%h required 0", b_addr, b_wdata, b_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(8);
    clear_logs();
    send_byte(8'h11); send_byte(8'h12); send_byte(8'h13); send_byte(8'h14);
    wait_cycles(3);
    n_chk++; if (b_addr_log.size() != 1) $display("FAIL midrst_write_count got %0d required 1", b_addr_log.size()); else n_pass++;
    if (b_addr_log.size() == 1) begin
      n_chk++; if (b_addr_log[0] !== 6'd0 || b_data_log[0] !== 32'h14131211) $display("FAIL midrst_write got addr=%h data=%h required 00/14131211", b_addr_log[0], b_data_log[0]); else n_pass++;
    end
    n_chk++; if (b_cnt !== 7'd1) $display("FAIL midrst_cnt got %0d required 1", b_cnt); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    b_acks = 0; s_acks = 0;
    b_ack_prev = 1'b0; s_ack_prev = 1'b0;
    test_reset();
    test_run_ignores_strobe();
    test_single_word();
    test_two_words();
    test_overflow();
    test_partial_word();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_byte_loader.md
Name: imem_byte_loader

Overview:
- Host-to-CPU input path; complements the core's 16-bit result output on uo_out/uio_out.
- Receives program bytes from the TinyTapeout input pins via a strobe/ack handshake.
- Assembles bytes into 32-bit little-endian instruction words and writes them into the CPU instruction memory.
- Holds the pipelined core in reset while a load is in progress, then releases it to run.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous strobe input (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  8  program byte (ui_in); host holds it stable from before the strobe rises until ack toggles
- byte_stb  in  1  host strobe, asynchronous to clk; a rising edge offers one byte
- load_en  in  1  level signal, synchronised internally; 1 = loading mode, 0 = run mode
- byte_ack  out  1  toggles once per accepted byte
- imem_we  out  1  one-cycle instruction-memory write pulse
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  assembled instruction word
- cpu_rst_n  out  1  active-low reset to the CPU core
- busy  out  1  high in state LOAD
- overflow  out  1  sticky flag: a word arrived after memory was full
- word_cnt  out  ADDR_W+1  number of words written in the current or last load

Behaviour:
- Reset values: all outputs 0. cpu_rst_n=0, byte_ack=0, state=IDLE, byte index=0, address=0.
- Synchronisation:
  - byte_stb and load_en each pass through SYNC_STAGES flops.
  - A rising edge of the synchronised byte_stb gives a one-cycle stb_pulse.
  - Pin-to-pulse latency is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: after reset. Go to LOAD if the synced load_en is 1, else go to RUN.
  - LOAD: busy=1, cpu_rst_n=0. On entry, clear byte index, address, word_cnt and overflow.
  - RUN: cpu_rst_n=1 (registered, asserted the cycle after entry), busy=0.
  - RUN→LOAD when synced load_en rises; this is a reload and it re-asserts cpu_rst_n=0 the next cycle.
  - LOAD→RUN when synced load_en falls.
- Byte capture (LOAD only):
  - On stb_pulse, write data_in into byte lane [8*idx +: 8] of the shift register, increment idx modulo 4, and toggle byte_ack in the same cycle.
  - byte_stb pulses in IDLE and RUN are ignored: no ack, no capture.
- Word write:
  - When the 4th byte is captured (idx 3→0), assert imem_we for exactly one cycle on the following cycle.
  - imem_wdata = {b3,b2,b1,b0}; imem_addr = current address.
  - After the write, increment the address and word_cnt.
  - Write latency is 1 cycle from the capture of the 4th byte.
- Full condition:
  - Once word_cnt = 2**ADDR_W, further completed words do not assert imem_we and do not advance the address.
  - Such a word sets overflow=1; overflow stays set until the next LOAD entry.
  - Bytes are still acked so the host never hangs.
- Partial word at exit: if load_en falls with idx≠0, discard the partial bytes and write nothing; idx is cleared on the next LOAD entry.
- Simultaneous events: if stb_pulse and the falling edge of load_en occur in the same cycle, the exit wins and the byte is not acked.
- Outside a write cycle: imem_wdata and imem_addr hold their last values; imem_we=0.
- Reset mid-load: everything returns to the reset values at once (asynchronous). Memory contents are not touched. The CPU stays in reset until the next RUN.

Decomposition:
- Shared package `tt_cpu_pkg`:
  - state enum (LOADER_IDLE, LOADER_LOAD, LOADER_RUN)
  - constant INSTR_W=32, BYTES_PER_WORD=4
  - default IMEM_ADDR_W=6
- One sub-module `sync_edge_det`: SYNC_STAGES flop chain plus a rising-edge pulse output. Instantiate it for byte_stb; reuse it (with a falling-edge output) for load_en.

Test Plan:
- Reset, then load_en=0 → after SYNC_STAGES+2 cycles: state RUN, cpu_rst_n=1, imem_we never pulses, byte_ack=0.
- load_en=1, then bytes 0x13,0x05,0xA0,0x00 → exactly one imem_we pulse with addr=0, wdata=0x00A00513; byte_ack toggles 4 times; word_cnt=1.
- Eight bytes 0x01..0x08 → writes addr0=0x04030201 and addr1=0x08070605; word_cnt=2; then drop load_en → cpu_rst_n=1.
- ADDR_W=2: send 5 words → four writes at addr 0..3; the 5th word gives no imem_we, overflow=1, word_cnt=4, and still produces 4 acks.
- Send 2 bytes, then drop load_en → no write; reassert load_en and send 4 bytes → write at addr=0 containing only the new bytes; overflow=0.
- Assert rst_n=0 mid-word (idx=2) → all outputs 0 immediately; after release and a full load, the first write is at addr=0.
